// File: rtl/motor_arm_sequencer.sv
`default_nettype none
// ============================================================================
// motor_arm_sequencer
// Arms a motor output from DShot frames, applies throttle, executes direction
// commands and falls back to failsafe when good frames stop arriving.
// Revision: 1.0
// ============================================================================
module motor_arm_sequencer #(
    parameter int ARM_FRAMES     = 10,
    parameter int CMD_REPEAT     = 6,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        frameStrobe,
    input  logic [10:0] frameValue,
    input  logic        frameCrcOk,
    output logic [7:0]  outputSpeed,
    output logic        armed,
    output logic        failsafe,
    output logic        direction,
    output logic        cmdAck
);

    localparam int SC_W = $clog2(ARM_FRAMES + 1);
    localparam int RC_W = $clog2(CMD_REPEAT + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SC_W-1:0] c_ARM_FRAMES = SC_W'(ARM_FRAMES);
    localparam logic [RC_W-1:0] c_CMD_REPEAT = RC_W'(CMD_REPEAT);
    localparam logic [TO_W-1:0] c_TIMEOUT    = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SC_W-1:0] stop_q, stop_d;
    logic [RC_W-1:0] run_q, run_d;
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic [10:0]     prev_q, prev_d;
    logic [7:0]      speed_q, speed_d;
    logic            dir_q, dir_d;
    logic            ack_q, ack_d;

    logic            w_good;
    logic            w_stop;
    logic            w_cmd;
    logic            w_thr;
    logic            w_reach;
    logic [7:0]      w_thrSpeed;

    always_comb begin
        w_good     = frameStrobe & frameCrcOk;
        w_stop     = (frameValue == 11'd0);
        w_thr      = (frameValue >= 11'd48);
        w_cmd      = !w_stop && !w_thr;
        w_thrSpeed = 8'((frameValue - 11'd48) >> 3);
        w_reach    = 1'b0;

        state_d = state_q;
        stop_d  = stop_q;
        run_d   = run_q;
        tmo_d   = tmo_q;
        prev_d  = prev_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        ack_d   = 1'b0;

        if (w_good) begin
            tmo_d  = '0;
            prev_d = frameValue;

            unique case (state_q)
                ST_DISARMED, ST_FAILSAFE: begin
                    if (w_stop) begin
                        if (ARM_FRAMES <= 1) begin
                            state_d = ST_ARMED;
                            stop_d  = '0;
                        end else begin
                            state_d = ST_ARMING;
                            stop_d  = SC_W'(1);
                        end
                    end
                end
                ST_ARMING: begin
                    if (w_stop) begin
                        if (stop_q + 1'b1 >= c_ARM_FRAMES) begin
                            state_d = ST_ARMED;
                            stop_d  = '0;
                        end else begin
                            stop_d = stop_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_DISARMED;
                        stop_d  = '0;
                    end
                end
                ST_ARMED: begin
                    if (w_thr) begin
                        speed_d = w_thrSpeed;
                    end else if (w_stop) begin
                        speed_d = 8'd0;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase

            // Commands only count while armed and stationary; the run saturates
            // once it reaches the repeat threshold so execution fires once.
            if (w_cmd && state_q == ST_ARMED && speed_q == 8'd0) begin
                if (frameValue == prev_q) begin
                    if (run_q != c_CMD_REPEAT) begin
                        run_d   = run_q + 1'b1;
                        w_reach = (run_q + 1'b1 == c_CMD_REPEAT);
                    end
                end else begin
                    run_d   = RC_W'(1);
                    w_reach = (CMD_REPEAT == 1);
                end
                if (w_reach) begin
                    if (frameValue == 11'd7 || frameValue == 11'd20) begin
                        dir_d = 1'b0;
                        ack_d = 1'b1;
                    end else if (frameValue == 11'd8 || frameValue == 11'd21) begin
                        dir_d = 1'b1;
                        ack_d = 1'b1;
                    end
                end
            end else begin
                run_d = '0;
            end
        end else begin
            if (tmo_q != c_TIMEOUT) begin
                tmo_d = tmo_q + 1'b1;
            end
            if (tmo_d == c_TIMEOUT &&
                (state_q == ST_ARMING || state_q == ST_ARMED)) begin
                state_d = ST_FAILSAFE;
                speed_d = 8'd0;
                stop_d  = '0;
                run_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= ST_DISARMED;
            stop_q  <= '0;
            run_q   <= '0;
            tmo_q   <= '0;
            prev_q  <= '0;
            speed_q <= '0;
            dir_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            run_q   <= run_d;
            tmo_q   <= tmo_d;
            prev_q  <= prev_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            ack_q   <= ack_d;
        end
    end

    assign outputSpeed = speed_q;
    assign armed       = (state_q == ST_ARMED);
    assign failsafe    = (state_q == ST_FAILSAFE);
    assign direction   = dir_q;
    assign cmdAck      = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_arm_sequencer.sv
`default_nettype none
// ============================================================================
// tb_motor_arm_sequencer
// Directed vector table plus hand-written multi-cycle sequences.
// Revision: 1.0
// ============================================================================
module tb_motor_arm_sequencer;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rstN;
    logic        frameStrobe;
    logic [10:0] frameValue;
    logic        frameCrcOk;
    logic [7:0]  outputSpeed;
    logic        armed;
    logic        failsafe;
    logic        direction;
    logic        cmdAck;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    motor_arm_sequencer #(
        .ARM_FRAMES    (10),
        .CMD_REPEAT    (6),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clk        (clk),
        .rstN       (rstN),
        .frameStrobe(frameStrobe),
        .frameValue (frameValue),
        .frameCrcOk (frameCrcOk),
        .outputSpeed(outputSpeed),
        .armed      (armed),
        .failsafe   (failsafe),
        .direction  (direction),
        .cmdAck     (cmdAck)
    );

    typedef struct {
        logic        strobe;
        logic [10:0] val;
        logic        crc;
        logic [7:0]  speed;
        logic        arm;
        logic        fs;
        logic        dir;
        logic        ack;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input int v, input logic c, input int sp,
                       input logic a, input logic f, input logic d, input logic k);
        vec_t e;
        e.strobe = s; e.val = 11'(v); e.crc = c; e.speed = 8'(sp);
        e.arm = a; e.fs = f; e.dir = d; e.ack = k;
        vecs.push_back(e);
    endtask

    task automatic add_n(input int n, input int v, input int sp, input logic d);
        for (int i = 0; i < n; i++) add(1'b1, v, 1'b1, sp, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic step(input logic s, input logic [10:0] v, input logic c);
        @(negedge clk);
        frameStrobe = s;
        frameValue  = v;
        frameCrcOk  = c;
        @(posedge clk);
        #1;
        frameStrobe = 1'b0;
    endtask

    task automatic frames(input int n, input int v);
        for (int i = 0; i < n; i++) step(1'b1, 11'(v), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 11'd0, 1'b1);
    endtask

    task automatic do_reset(input logic [10:0] v);
        @(negedge clk);
        rstN        = 1'b0;
        frameStrobe = 1'b1;
        frameValue  = v;
        frameCrcOk  = 1'b1;
        @(posedge clk);
        #1;
        rstN        = 1'b1;
        frameStrobe = 1'b0;
    endtask

    task automatic check(input string name, input int sp, input logic a,
                         input logic f, input logic d, input logic k);
        n_checks++;
        if ({outputSpeed, armed, failsafe, direction, cmdAck} !== {8'(sp), a, f, d, k}) begin
            n_errors++;
            $display("FAIL %s: got speed=%0d armed=%b failsafe=%b dir=%b ack=%b, expected speed=%0d armed=%b failsafe=%b dir=%b ack=%b",
                     name, outputSpeed, armed, failsafe, direction, cmdAck, sp, a, f, d, k);
        end
    endtask

    initial begin
        rstN        = 1'b1;
        frameStrobe = 1'b0;
        frameValue  = '0;
        frameCrcOk  = 1'b0;

        for (int i = 0; i < 9; i++) add(1'b1, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1,    0, 1'b1,   0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 2047, 1'b1, 249, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1,   48, 1'b1,   0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1,  855, 1'b1, 100, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1000, 1'b0, 100, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1,   55, 1'b1,   0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1,   56, 1'b1,   1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1,    0, 1'b1,   0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_n(5, 21, 0, 1'b0);
        add(1'b1,   21, 1'b1,   0, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1,   21, 1'b1,   0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0,    0, 1'b1,   0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1,  848, 1'b1, 100, 1'b1, 1'b0, 1'b1, 1'b0);
        add_n(6, 20, 100, 1'b1);
        add(1'b1,    0, 1'b1,   0, 1'b1, 1'b0, 1'b1, 1'b0);
        add_n(5, 7, 0, 1'b1);
        add(1'b1,    7, 1'b1,   0, 1'b1, 1'b0, 1'b0, 1'b1);
        add_n(5, 8, 0, 1'b0);
        add_n(1, 7, 0, 1'b0);
        add_n(5, 8, 0, 1'b0);
        add(1'b1,    8, 1'b1,   0, 1'b1, 1'b0, 1'b1, 1'b1);
        add_n(6, 5, 0, 1'b1);
        add_n(3, 7, 0, 1'b1);
        add(1'b1,    7, 1'b0,   0, 1'b1, 1'b0, 1'b1, 1'b0);
        add_n(2, 7, 0, 1'b1);
        add(1'b1,    7, 1'b1,   0, 1'b1, 1'b0, 1'b0, 1'b1);

        do_reset(11'd0);
        check("reset_state", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (vecs[i]) begin
            step(vecs[i].strobe, vecs[i].val, vecs[i].crc);
            check($sformatf("vec%0d", i), vecs[i].speed, vecs[i].arm,
                  vecs[i].fs, vecs[i].dir, vecs[i].ack);
        end

        // Arm abort leaves a fresh run of five stops
        do_reset(11'd0);
        frames(5, 0);
        frames(1, 1000);
        check("abort_throttle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(5, 0);
        check("abort_5stops", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(4, 0);
        check("abort_9stops", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(1, 0);
        check("abort_10stops", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Timeout from ARMED; bad-CRC frame counts as idle
        frames(1, 855);
        check("tmo_speed", 100, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 11'd1000, 1'b0);
        idle(TMO - 2);
        check("tmo_just_before", 100, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("tmo_failsafe", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(1, 1000);
        check("fs_throttle_ignored", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(1, 0);
        check("fs_stop_to_arming", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(8, 0);
        check("fs_rearm_9", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(1, 0);
        check("fs_rearm_10", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // A good frame on the would-be timeout cycle wins
        idle(TMO - 1);
        frames(1, 48);
        check("tmo_priority", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(TMO - 1);
        check("tmo_priority_restart", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("tmo_priority_fire", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Timeout ignored in DISARMED, honoured in ARMING
        do_reset(11'd0);
        idle(TMO + 5);
        check("tmo_disarmed", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(3, 0);
        idle(TMO - 1);
        check("tmo_arming_before", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("tmo_arming_fire", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Direction persists through failsafe; reset clears everything
        do_reset(11'd0);
        frames(10, 0);
        frames(6, 21);
        check("dir_set", 0, 1'b1, 1'b0, 1'b1, 1'b1);
        frames(1, 1648);
        check("speed_200", 200, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(TMO);
        check("dir_in_failsafe", 0, 1'b0, 1'b1, 1'b1, 1'b0);
        frames(10, 0);
        check("dir_after_rearm", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        frames(1, 1648);
        do_reset(11'd2047);
        check("reset_clears", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(1, 2047);
        check("reset_disarmed", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid command-run discards the partial run
        frames(10, 0);
        frames(5, 8);
        do_reset(11'd8);
        frames(10, 0);
        frames(1, 8);
        check("midrun_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        frames(5, 8);
        check("midrun_fresh_run", 0, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_arm_sequencer.md
MOTOR_ARM_SEQUENCER -- requirements
Module: motor_arm_sequencer

Interface
REQ-001 SHALL have parameter ARM_FRAMES, default 10: consecutive CRC-valid stop frames required to arm.
REQ-002 SHALL have parameter CMD_REPEAT, default 6: consecutive identical CRC-valid command frames required to execute a command.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 48000: clk cycles without a CRC-valid frame before failsafe.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rstN  input  1  synchronous active-low reset.
REQ-006 SHALL have port frameStrobe  input  1  one-cycle pulse; frame decode complete.
REQ-007 SHALL have port frameValue  input  11  raw DShot value, 0..2047, sampled only when frameStrobe=1.
REQ-008 SHALL have port frameCrcOk  input  1  CRC result for frameValue, sampled with frameStrobe.
REQ-009 SHALL have port outputSpeed  output  8  motor speed, 0..249.
REQ-010 SHALL have port armed  output  1  high in ARMED state only.
REQ-011 SHALL have port failsafe  output  1  high in FAILSAFE state only.
REQ-012 SHALL have port direction  output  1  0 normal, 1 reversed.
REQ-013 SHALL have port cmdAck  output  1  one-cycle pulse when a command executes.

Function
REQ-014 SHALL treat a "good frame" as frameStrobe=1 with frameCrcOk=1; frames with frameCrcOk=0 SHALL be ignored entirely (no counter, state or timeout effect).
REQ-015 SHALL classify good frames as: stop (value 0), command (1..47), throttle (48..2047).
REQ-016 SHALL implement states DISARMED, ARMING, ARMED, FAILSAFE; outputSpeed SHALL be 0 in every state except ARMED.
REQ-017 DISARMED: good stop frame -> ARMING with stop count 1; other good frames -> no change.
REQ-018 ARMING: good stop frame increments stop count; on the frame where count reaches ARM_FRAMES -> ARMED; good non-stop frame -> DISARMED, count cleared.
REQ-019 ARMED: throttle frame SHALL set outputSpeed = (frameValue-48)>>3 (2047 -> 249, 48 -> 0); stop frame SHALL set outputSpeed 0; state stays ARMED.
REQ-020 All outputs SHALL update on the clk edge following the frameStrobe cycle (latency 1 cycle).
REQ-021 Command run counter SHALL increment on each good command frame equal to the previous good frame's value, restart at 1 on a different command value, and clear on any good stop or throttle frame.
REQ-022 Commands SHALL be evaluated only in ARMED with outputSpeed=0; otherwise the run counter SHALL clear.
REQ-023 On the frame where run count reaches CMD_REPEAT: command 7 or 20 sets direction 0, command 8 or 21 sets direction 1, and cmdAck pulses for that cycle; other command values SHALL execute nothing and not pulse cmdAck.
REQ-024 After execution the run counter SHALL saturate; further identical frames SHALL NOT re-pulse cmdAck until the run is broken.
REQ-025 Timeout counter SHALL clear on every good frame, increment otherwise, and saturate at TIMEOUT_CYCLES.
REQ-026 Reaching TIMEOUT_CYCLES in ARMING or ARMED SHALL enter FAILSAFE on that edge with outputSpeed 0; in DISARMED or FAILSAFE it SHALL have no effect.
REQ-027 A good frame in the same cycle the counter would reach TIMEOUT_CYCLES SHALL take priority (counter clears, no failsafe).
REQ-028 FAILSAFE: good stop frame -> ARMING with stop count 1; good non-stop frames -> remain FAILSAFE.
REQ-029 direction SHALL persist across DISARMED/ARMING/FAILSAFE transitions; only reset or command execution changes it.

Reset
REQ-030 With rstN=0 at a clk edge: state DISARMED, outputSpeed 0, armed 0, failsafe 0, direction 0, cmdAck 0, all counters 0; applies mid-frame and mid-run, any frameStrobe in that cycle discarded.

Verification
REQ-031 Arm: 10 good stop frames then throttle 2047 -> armed=1 after 10th frame, outputSpeed=249 one cycle after throttle strobe.
REQ-032 Arm abort: 5 stop frames, throttle 1000, 5 stop frames -> armed=0, state ARMING with count 5.
REQ-033 CRC drop: armed, throttle 1000 with frameCrcOk=0 -> outputSpeed unchanged; TIMEOUT_CYCLES idle cycles -> failsafe=1, outputSpeed=0; 1 stop frame -> failsafe=0, ARMING.
REQ-034 Direction: armed at speed 0, six command-21 frames -> direction=1, single cmdAck on 6th; seventh command-21 frame -> no cmdAck; repeat with outputSpeed=100 -> no change.
REQ-035 Run break: armed, five command-8 frames, one command-7, five command-8 -> no cmdAck, direction unchanged.
REQ-036 Reset: armed, direction=1, outputSpeed=200, pulse rstN low one cycle -> all outputs 0, DISARMED.
